// File: rtl/button_pio_pkg.sv
// Shared definitions for the button PIO: register word addresses and edge-type encoding.
package button_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

endpackage

// File: rtl/button_pio_debounce.sv
// Single-bit two-flop synchroniser, debounce counter and filtered level with edge events.
module button_pio_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic filt,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Events are combinational so the capture register sets on the same edge filt changes.
  assign accept   = (s2 != filt) && (cnt == CNT_LAST);
  assign rise_evt = accept && s2;
  assign fall_evt = accept && !s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= RESET_LEVEL;
      s2   <= RESET_LEVEL;
      filt <= RESET_LEVEL;
      cnt  <= '0;
    end else begin
      s1 <= in_bit;
      s2 <= s1;
      if (s2 == filt) begin
        cnt <= '0;
      end else if (accept) begin
        filt <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/my_nios2_system_button_pio.sv
// Avalon-MM input PIO: debounced inputs, edge capture with write-1-clear, maskable level irq.
module my_nios2_system_button_pio
  import button_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam edge_type_e ETYPE = edge_type_e'(EDGE_TYPE[1:0]);

  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] rise_evt;
  logic [WIDTH-1:0] fall_evt;
  logic [WIDTH-1:0] set_evt;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] cap;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;
  assign wr_en        = chipselect && !write_n;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    button_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL[i])
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .in_bit  (in_port[i]),
      .filt    (filt[i]),
      .rise_evt(rise_evt[i]),
      .fall_evt(fall_evt[i])
    );
  end

  always_comb begin
    set_evt = rise_evt | fall_evt;
    case (ETYPE)
      EDGE_RISE: set_evt = rise_evt;
      EDGE_FALL: set_evt = fall_evt;
      default:   set_evt = rise_evt | fall_evt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= '0;
      cap  <= '0;
    end else begin
      if (wr_en && address == ADDR_MASK) begin
        mask <= writedata[WIDTH-1:0];
      end
      // A new event in the same cycle as its clear keeps the bit set.
      if (wr_en && address == ADDR_EDGE) begin
        cap <= (cap & ~writedata[WIDTH-1:0]) | set_evt;
      end else begin
        cap <= cap | set_evt;
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = filt;
      ADDR_MASK: readdata[WIDTH-1:0] = mask;
      ADDR_EDGE: readdata[WIDTH-1:0] = cap;
      default:   readdata = '0;
    endcase
  end

  assign irq = |(cap & mask);

endmodule

// File: tb/tb_my_nios2_system_button_pio.sv
// Directed bench: instance a uses falling-edge capture, instance b any-edge; both debounce 8 cycles.
module tb_my_nios2_system_button_pio;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [3:0]  in_a = 4'hF;
  logic [3:0]  in_b = 4'hF;
  logic [31:0] readdata_a;
  logic [31:0] readdata_b;
  logic        irq_a;
  logic        irq_b;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  my_nios2_system_button_pio #(
    .WIDTH(4), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(1), .RESET_LEVEL(4'hF)
  ) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(readdata_a), .irq(irq_a)
  );

  my_nios2_system_button_pio #(
    .WIDTH(4), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(2), .RESET_LEVEL(4'hF)
  ) dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_b),
    .readdata(readdata_b), .irq(irq_b)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] da, output logic [31:0] db);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    da = readdata_a;
    db = readdata_b;
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] da, db;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    rd(2'd0, da, db);
    n_cmp++; if (da !== 32'hF) begin n_fail++; $display("FAIL reset_data_a got %h want %h", da, 32'hF); end
    n_cmp++; if (db !== 32'hF) begin n_fail++; $display("FAIL reset_data_b got %h want %h", db, 32'hF); end
    rd(2'd2, da, db);
    n_cmp++; if (da !== 32'h0) begin n_fail++; $display("FAIL reset_mask got %h want %h", da, 32'h0); end
    rd(2'd3, da, db);
    n_cmp++; if (da !== 32'h0) begin n_fail++; $display("FAIL reset_cap got %h want %h", da, 32'h0); end
    n_cmp++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want %b", irq_a, 1'b0); end
    wr(2'd0, 32'h0);
    wr(2'd1, 32'hF);
    rd(2'd0, da, db);
    n_cmp++; if (da !== 32'hF) begin n_fail++; $display("FAIL data_write_ignored got %h want %h", da, 32'hF); end
    rd(2'd1, da, db);
    n_cmp++; if (da !== 32'h0) begin n_fail++; $display("FAIL reserved_read got %h want %h", da, 32'h0); end
  endtask

  task automatic test_latency;
    logic [31:0] da, db;
    in_a[0] = 1'b0;
    tick(9);
    rd(2'd0, da, db);
    n_cmp++; if (da !== 32'hF) begin n_fail++; $display("FAIL latency_early_filt got %h want %h", da, 32'hF); end
    rd(2'd3, da, db);
    n_cmp++; if (da !== 32'h0) begin n_fail++; $display("FAIL latency_early_cap got %h want %h", da, 32'h0); end
    tick(1);
    rd(2'd0, da, db);
    n_cmp++; if (da !== 32'hE) begin n_fail++; $display("FAIL latency_filt got %h want %h", da, 32'hE); end
    rd(2'd3, da, db);
    n_cmp++; if (da !== 32'h1) begin n_fail++; $display("FAIL latency_cap got %h want %h", da, 32'h1); end
    n_cmp++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL latency_irq_masked got %b want %b", irq_a, 1'b0); end
    wr(2'd3, 32'h1);
    in_a[0] = 1'b1;
    tick(12);
    rd(2'd3, da, db);
    n_cmp++; if (da !== 32'h0) begin n_fail++; $display("FAIL rise_ignored_cap got %h want %h", da, 32'h0); end
    rd(2'd0, da, db);
    n_cmp++; if (da !== 32'hF) begin n_fail++; $display("FAIL release_filt got %h want %h", da, 32'hF); end
  endtask

  task automatic test_glitch;
    logic [31:0] da, db;
    in_a[2] = 1'b0;
    tick(7);
    in_a[2] = 1'b1;
    tick(12);
    rd(2'd0, da, db);
    n_cmp++; if (da !== 32'hF) begin n_fail++; $display("FAIL glitch7_filt got %h want %h", da, 32'hF); end
    rd(2'd3, da, db);
    n_cmp++; if (da !== 32'h0) begin n_fail++; $display("FAIL glitch7_cap got %h want %h", da, 32'h0); end
    n_cmp++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL glitch7_irq got %b want %b", irq_a, 1'b0); end
    in_a[2] = 1'b0;
    tick(8);
    in_a[2] = 1'b1;
    tick(12);
    rd(2'd3, da, db);
    n_cmp++; if (da !== 32'h4) begin n_fail++; $display("FAIL glitch8_cap got %h want %h", da, 32'h4); end
    wr(2'd3, 32'h4);
    rd(2'd3, da, db);
    n_cmp++; if (da !== 32'h0) begin n_fail++; $display("FAIL glitch8_clear got %h want %h", da, 32'h0); end
  endtask

  task automatic test_irq;
    logic [31:0] da, db;
    wr(2'd2, 32'h3);
    rd(2'd2, da, db);
    n_cmp++; if (da !== 32'h3) begin n_fail++; $display("FAIL mask_read got %h want %h", da, 32'h3); end
    in_a[1] = 1'b0;
    tick(10);
    n_cmp++; if (irq_a !== 1'b1) begin n_fail++; $display("FAIL irq_assert got %b want %b", irq_a, 1'b1); end
    rd(2'd3, da, db);
    n_cmp++; if (da !== 32'h2) begin n_fail++; $display("FAIL irq_cap got %h want %h", da, 32'h2); end
    wr(2'd3, 32'h1);
    rd(2'd3, da, db);
    n_cmp++; if (da !== 32'h2) begin n_fail++; $display("FAIL clear_other_bit got %h want %h", da, 32'h2); end
    n_cmp++; if (irq_a !== 1'b1) begin n_fail++; $display("FAIL irq_held got %b want %b", irq_a, 1'b1); end
    wr(2'd3, 32'h2);
    n_cmp++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b want %b", irq_a, 1'b0); end
    in_a[1] = 1'b1;
    tick(12);
    wr(2'd2, 32'h0);
    in_a[3] = 1'b0;
    tick(10);
    n_cmp++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL irq_masked_out got %b want %b", irq_a, 1'b0); end
    wr(2'd2, 32'h8);
    n_cmp++; if (irq_a !== 1'b1) begin n_fail++; $display("FAIL irq_unmask got %b want %b", irq_a, 1'b1); end
    wr(2'd3, 32'h8);
    in_a[3] = 1'b1;
    tick(12);
    wr(2'd2, 32'h0);
  endtask

  task automatic test_simultaneous;
    logic [31:0] da, db;
    in_a[0] = 1'b0;
    tick(9);
    wr(2'd3, 32'h1);
    rd(2'd3, da, db);
    n_cmp++; if (da !== 32'h1) begin n_fail++; $display("FAIL set_beats_clear got %h want %h", da, 32'h1); end
    wr(2'd3, 32'h1);
    rd(2'd3, da, db);
    n_cmp++; if (da !== 32'h0) begin n_fail++; $display("FAIL later_clear got %h want %h", da, 32'h0); end
    in_a[0] = 1'b1;
    tick(12);
  endtask

  task automatic test_edge_any;
    logic [31:0] da, db;
    in_b[0] = 1'b0;
    tick(10);
    rd(2'd3, da, db);
    n_cmp++; if (db !== 32'h1) begin n_fail++; $display("FAIL any_press_cap got %h want %h", db, 32'h1); end
    wr(2'd3, 32'h1);
    rd(2'd3, da, db);
    n_cmp++; if (db !== 32'h0) begin n_fail++; $display("FAIL any_clear got %h want %h", db, 32'h0); end
    in_b[0] = 1'b1;
    tick(10);
    rd(2'd3, da, db);
    n_cmp++; if (db !== 32'h1) begin n_fail++; $display("FAIL any_release_cap got %h want %h", db, 32'h1); end
    wr(2'd3, 32'h1);
  endtask

  task automatic test_reset_midcount;
    logic [31:0] da, db;
    wr(2'd2, 32'hF);
    in_a[1] = 1'b0;
    tick(10);
    n_cmp++; if (irq_a !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq got %b want %b", irq_a, 1'b1); end
    in_a[1] = 1'b1;
    in_a[2] = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    in_a = 4'hF;
    n_cmp++; if (irq_a !== 1'b0) begin n_fail++; $display("FAIL reset_mid_irq got %b want %b", irq_a, 1'b0); end
    rd(2'd0, da, db);
    n_cmp++; if (da !== 32'hF) begin n_fail++; $display("FAIL reset_mid_filt got %h want %h", da, 32'hF); end
    rd(2'd2, da, db);
    n_cmp++; if (da !== 32'h0) begin n_fail++; $display("FAIL reset_mid_mask got %h want %h", da, 32'h0); end
    tick(12);
    rd(2'd3, da, db);
    n_cmp++; if (da !== 32'h0) begin n_fail++; $display("FAIL reset_mid_cap got %h want %h", da, 32'h0); end
    rd(2'd0, da, db);
    n_cmp++; if (da !== 32'hF) begin n_fail++; $display("FAIL reset_mid_filt_late got %h want %h", da, 32'hF); end
  endtask

  initial begin
    tick(1);
    test_reset;
    test_latency;
    test_glitch;
    test_irq;
    test_simultaneous;
    test_edge_any;
    test_reset_midcount;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/my_nios2_system_button_pio.md
# my_nios2_system_button_pio

Avalon-MM slave input PIO for the Nios II system. It is the input-direction counterpart to the LED output PIO. It samples a bank of external push-buttons or switches, synchronises and debounces each bit, and latches edges into a capture register. It raises a maskable interrupt to the CPU. It sits on the system interconnect beside the LED PIO and uses the same 2-bit word address, zero-wait-state slave protocol.

## Interface
Parameters:
- `WIDTH`, 4: number of input bits.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required before a bit change is accepted. Legal range is 1 or more; a value of 1 gives synchronisation only.
- `EDGE_TYPE`, 1: edge that sets a capture bit. 0 = rising, 1 = falling, 2 = any.
- `RESET_LEVEL`, all ones (`WIDTH` bits): idle level of `in_port`. Loaded at reset so that no spurious edge follows reset.

Ports:
- `clk`  in  1: system clock. Only clock.
- `reset`  in  1: synchronous, active-high reset.
- `address`  in  2: word address.
- `chipselect`  in  1: slave select.
- `write_n`  in  1: active-low write strobe.
- `writedata`  in  32: write data.
- `in_port`  in  `WIDTH`: asynchronous external inputs.
- `readdata`  out  32: read data. Combinational and zero-wait.
- `irq`  out  1: level interrupt to the CPU.

## Operation
- Register map (unused `readdata` bits read 0):
  - Address 0, DATA (RO): debounced input value `filt`. Writes are ignored.
  - Address 1: reserved. Reads 0; writes are ignored.
  - Address 2, IRQ_MASK (RW): `mask[WIDTH-1:0]`.
  - Address 3, EDGE_CAPTURE (R/W1C): `cap[WIDTH-1:0]`. Writing 1 to a bit clears that bit.
- A write occurs when `chipselect && !write_n`. Reads have no side effects.
- Input path per bit:
  - Two-flop synchroniser: `s1` then `s2`.
  - Debounce counter `cnt`.
  - Filtered register `filt`.
- Debounce rules, per bit:
  - If `s2 == filt`, then `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`, then `filt <= s2` and `cnt <= 0`.
  - Otherwise `cnt <= cnt+1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches `filt`.
- Edge capture: a bit's update event is the cycle in which `filt` changes.
  - `cap[i]` is set at that same edge if the direction matches `EDGE_TYPE`.
  - `cap[i]` stays set until cleared by a write-1.
- `irq = |(cap & mask)`. It is driven directly from registers, with no combinational path from the bus.
- Counter width is `$clog2(DEBOUNCE_CYCLES+1)`. The counter cannot exceed `DEBOUNCE_CYCLES-1`, so it never wraps.

## Timing
- Reset values:
  - `s1`, `s2` and `filt` = `RESET_LEVEL`.
  - `cnt` = 0, `mask` = 0, `cap` = 0.
  - `irq` = 0, and `readdata` for address 0 = `RESET_LEVEL`.
- Input latency: `in_port` changes and is held, first sampled at edge k. Then:
  - `filt` and `cap` update at edge k+1+`DEBOUNCE_CYCLES`.
  - `irq` is high after that same edge if the bit is masked in.
- Bus: `readdata` is valid in the same cycle as `address`. Written registers take their new value at the write edge.
- Clear and new edge in the same cycle: set wins, so `cap[i]` remains 1.
- Mask write: affects `irq` from the next cycle. Unmasking a bit that is already captured asserts `irq` immediately after the write edge.
- Input returning to `filt` mid-count: `cnt` resets to 0 and no event occurs.
- Reset mid-count or while `irq` is asserted: all state returns to reset values at the next edge. Any in-flight debounce is discarded.

## Structure
- Shared package `button_pio_pkg`:
  - Register address constants `ADDR_DATA`, `ADDR_MASK`, `ADDR_EDGE`.
  - Edge-type enum with `EDGE_RISE`, `EDGE_FALL`, `EDGE_ANY`.
- One sub-module, `button_pio_debounce`. It is a single-bit synchroniser, debounce counter and `filt` register. It outputs `filt`, `rise_evt` and `fall_evt`, and is instantiated `WIDTH` times by a generate loop.
- Top level holds the register file, capture logic, read mux and `irq`.

## Test plan
- Reset value read: after `reset`, read address 0 -> `0xF`. Read address 2 -> 0. Read address 3 -> 0. `irq` = 0.
- Debounce latency, with `DEBOUNCE_CYCLES`=8: drive `in_port[0]` 1->0 and hold it. Expect `filt[0]` to fall and `cap[0]` to set exactly 9 edges after first sample. `irq` stays 0 while the mask is 0.
- Glitch rejection, with `DEBOUNCE_CYCLES`=8: pulse `in_port[2]` low for 7 cycles -> `filt`, `cap` and `irq` are unchanged. Pulse low for 8 cycles -> `cap[2]` = 1.
- Interrupt flow:
  - Write mask = `0x3` and press `in_port[1]`. `irq` goes to 1 and address 3 reads `0x2`.
  - Write `0x2` to address 3. `irq` goes to 0 the next cycle.
  - Writing `0x1` instead leaves `cap` at `0x2`.
- Simultaneous clear and edge: schedule the write-1-clear of `cap[0]` in the same cycle as a new debounced falling event on bit 0 -> `cap[0]` remains 1.
- Edge type and reset mid-count:
  - With `EDGE_TYPE`=2, a press then release sets `cap` on both edges.
  - Asserting `reset` halfway through a debounce count -> no capture, and `filt` = `0xF`.
